matrix_index_walker: RTL and testbench

//  Sequencer that walks every element index of a rows x cols matrix.
//  It emits one (row, col, addr) beat per element over a valid/ready stream.

---
 rtl/matrix_index_walker.sv | 142 ++++++++++++++
 tb/tb_matrix_index_walker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_index_walker.sv
// Handshaked index sequencer that walks every element of a rows x cols matrix,
// row-major or column-major, emitting registered (row, col, addr) beats.
module matrix_index_walker #(
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              transpose,
    input  logic [ROW_W-1:0]  rows,
    input  logic [COL_W-1:0]  cols,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ROW_W-1:0]    rows_reg, rows_next;
    logic [COL_W-1:0]    cols_reg, cols_next;
    logic                transpose_reg, transpose_next;
    logic [ROW_W-1:0]    row_reg, row_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                valid_reg, valid_next;
    logic                last_reg, last_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic at_row_end;
    logic at_col_end;

    assign at_row_end = (row_reg == ROW_W'(rows_reg - 1'b1));
    assign at_col_end = (col_reg == COL_W'(cols_reg - 1'b1));

    always_comb begin
        state_next     = state_reg;
        rows_next      = rows_reg;
        cols_next      = cols_reg;
        transpose_next = transpose_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        addr_next      = addr_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    rows_next      = rows;
                    cols_next      = cols;
                    transpose_next = transpose;
                    row_next       = '0;
                    col_next       = '0;
                    addr_next      = '0;
                    state_next     = (rows != '0 && cols != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (valid_reg && out_ready) begin
                    if (last_reg) begin
                        state_next = DONE;
                    end else if (!transpose_reg) begin
                        addr_next = addr_reg + ADDR_W'(1);
                        if (at_col_end) begin
                            col_next = '0;
                            row_next = row_reg + ROW_W'(1);
                        end else begin
                            col_next = col_reg + COL_W'(1);
                        end
                    end else begin
                        // Column wrap restarts the address at the next column's
                        // top element, which is simply its column index.
                        if (at_row_end) begin
                            row_next  = '0;
                            col_next  = col_reg + COL_W'(1);
                            addr_next = ADDR_W'(col_reg) + ADDR_W'(1);
                        end else begin
                            row_next  = row_reg + ROW_W'(1);
                            addr_next = addr_reg + ADDR_W'(cols_reg);
                        end
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        valid_next = (state_next == RUN);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        last_next  = (state_next == RUN)
                   && (row_next == ROW_W'(rows_next - 1'b1))
                   && (col_next == COL_W'(cols_next - 1'b1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rows_reg      <= '0;
            cols_reg      <= '0;
            transpose_reg <= 1'b0;
            row_reg       <= '0;
            col_reg       <= '0;
            addr_reg      <= '0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rows_reg      <= rows_next;
            cols_reg      <= cols_next;
            transpose_reg <= transpose_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            addr_reg      <= addr_next;
            valid_reg     <= valid_next;
            last_reg      <= last_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_row   = row_reg;
    assign out_col   = col_reg;
    assign out_addr  = addr_reg;
    assign out_last  = last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_matrix_index_walker.sv
// Scoreboard bench for matrix_index_walker: stimulus queues expected beats and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_matrix_index_walker;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic        transpose;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic [15:0] out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    matrix_index_walker #(.ROW_W(8), .COL_W(8), .ADDR_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .transpose(transpose), .rows(rows), .cols(cols),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct {
        bit          is_done;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] addr;
        logic        last;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_accepted = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_beat(input int r, input int c, input int a, input bit l);
        exp_t e;
        e.is_done = 1'b0;
        e.row = 8'(r); e.col = 8'(c); e.addr = 16'(a); e.last = l;
        expq.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.row = '0; e.col = '0; e.addr = '0; e.last = 1'b0;
        expq.push_back(e);
    endtask

    task automatic push_rowmajor(input int nr, input int nc);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                push_beat(r, c, r * nc + c, (r == nr - 1) && (c == nc - 1));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_walk(input int nr, input int nc, input bit tr);
        rows = 8'(nr); cols = 8'(nc); transpose = tr; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check({name, "_idle_within_budget"}, 64'(busy), 64'd0);
    endtask

    // Monitor: an accepted beat is valid && ready with no abort overriding it.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready && !abort) begin
                n_accepted++;
                if (expq.size() == 0 || expq[0].is_done) begin
                    check("unexpected_beat", {16'(out_row), 16'(out_col), out_addr}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("beat", {15'd0, out_last, out_row, out_col, out_addr},
                          {15'd0, e.last, e.row, e.col, e.addr});
                end
            end
            if (done) begin
                if (expq.size() == 0 || !expq[0].is_done) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    void'(expq.pop_front());
                    check("done_pulse", 64'(done), 64'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; transpose = 1'b0;
        rows = '0; cols = '0; out_ready = 1'b1;
        #12;
        check("reset_outputs", {out_valid, out_last, busy, done, out_row, out_col, out_addr}, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: 2x3 row-major, six consecutive beats then a done pulse
        push_rowmajor(2, 3);
        push_done();
        start_walk(2, 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("t1_consecutive_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("t1_done_after_last", {out_valid, done}, {1'b0, 1'b1});
        tick();
        check("t1_idle_after_done", {busy, done}, 2'b00);

        // 2: 2x3 column-major
        push_beat(0, 0, 0, 0); push_beat(1, 0, 3, 0); push_beat(0, 1, 1, 0);
        push_beat(1, 1, 4, 0); push_beat(0, 2, 2, 0); push_beat(1, 2, 5, 1);
        push_done();
        start_walk(2, 3, 1'b1);
        wait_idle("t2", 30);

        // 3: 3x3 with a 4-cycle stall on beat (1,1)
        n_accepted = 0;
        push_rowmajor(3, 3);
        push_done();
        start_walk(3, 3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_frozen", {out_valid, out_row, out_col, out_addr}, {1'b1, 8'd1, 8'd1, 16'd4});
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t3_resume_addr", 64'(out_addr), 64'd5);
        wait_idle("t3", 30);
        check("t3_accepted_count", 64'(n_accepted), 64'd9);

        // 4: zero-sized walk, then a 1x1 walk
        push_done();
        start_walk(0, 5, 1'b0);
        check("t4_zero_done", {out_valid, busy, done}, 3'b011);
        tick();
        check("t4_zero_idle", {out_valid, busy, done}, 3'b000);
        push_beat(0, 0, 0, 1);
        push_done();
        start_walk(1, 1, 1'b0);
        check("t4_1x1_last", {out_valid, out_last}, 2'b11);
        wait_idle("t4", 10);

        // 5a: abort while beat 2 is on the bus
        push_beat(0, 0, 0, 0); push_beat(0, 1, 1, 0);
        start_walk(2, 3, 1'b0);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_idle", {out_valid, busy, done}, 3'b000);
        for (int i = 0; i < 3; i++) tick();

        // 5b: asynchronous reset while beat 4 is on the bus
        push_rowmajor(3, 3);
        for (int i = 0; i < 5; i++) void'(expq.pop_back());
        start_walk(3, 3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #2 reset = 1'b1;
        #1 check("t5_reset_immediate", {out_valid, out_last, busy, done, out_row, out_col, out_addr}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        push_rowmajor(2, 3);
        push_done();
        start_walk(2, 3, 1'b0);
        check("t5_restart_addr0", {out_valid, out_addr}, {1'b1, 16'd0});
        wait_idle("t5", 30);

        // 6: start with new config during RUN is ignored
        push_rowmajor(2, 3);
        push_done();
        start_walk(2, 3, 1'b0);
        tick(); tick();
        rows = 8'd5; cols = 8'd7; transpose = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t6", 30);
        for (int i = 0; i < 3; i++) tick();
        check("t6_no_restart", 64'(busy), 64'd0);

        check("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
